// File: rtl/reg_bank_if.sv
// Register-file access bundle: one write port and two read ports.
// The decode/writeback side uses master; the register file uses slave.
interface reg_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              write;
    logic [ADDR_W-1:0] dr;
    logic [DATA_W-1:0] wrdata;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output write, dr, wrdata, rs1, rs2,
        input  rdata1, rdata2
    );

    modport slave (
        input  write, dr, wrdata, rs1, rs2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_bank.sv
// 32x32 general-purpose register file: two combinational read ports, one clocked write port.
// Optional macro ZERO_REG_EN hardwires register 0 to zero (writes to it dropped, reads return 0).
module reg_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic        clock,
    input  logic        reset,
    reg_bank_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

`ifdef ZERO_REG_EN
    assign wr_en = bus.write && (bus.dr != '0);
`else
    assign wr_en = bus.write;
`endif

    // Reset clears every word and dominates any write on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.dr] <= bus.wrdata;
        end
    end

    // Reads see the stored contents only; a same-cycle write appears after the edge.
`ifdef ZERO_REG_EN
    assign bus.rdata1 = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
    assign bus.rdata2 = (bus.rs2 == '0) ? '0 : regs[bus.rs2];
`else
    assign bus.rdata1 = regs[bus.rs1];
    assign bus.rdata2 = regs[bus.rs2];
`endif
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vectors, corner sequences and
// randomized traffic checked against an array model of the register file.
`timescale 1ns/1ps
module tb_reg_bank;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    reg_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_bank #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // Architectural view of the register file.
    logic [31:0] mdl [32];

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (ZERO_REG && a == 5'd0) return 32'd0;
        return mdl[a];
    endfunction

    task automatic mdl_write(input logic [4:0] a, input logic [31:0] d);
        if (!(ZERO_REG && a == 5'd0)) mdl[a] = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_cycle(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.write  = 1'b1;
        bus.dr     = a;
        bus.wrdata = d;
        @(posedge clock);
        mdl_write(a, d);
    endtask

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].rs1  = 5'(2 * i);
            vecs[i].rs2  = 5'(2 * i + 1);
            vecs[i].exp1 = 32'(20 * i);
            vecs[i].exp2 = 32'(20 * i + 10);
        end

        reset      = 1'b1;
        bus.write  = 1'b0;
        bus.dr     = 5'd0;
        bus.wrdata = 32'd0;
        bus.rs1    = 5'd0;
        bus.rs2    = 5'd31;
        repeat (2) @(posedge clock);

        // Reset state
        @(negedge clock);
        #1;
        check("reset_rd1", bus.rdata1, 32'd0);
        check("reset_rd2", bus.rdata2, 32'd0);
        reset = 1'b0;

        // Fill reg k with 10*k
        for (int k = 0; k < 32; k++) write_cycle(5'(k), 32'(10 * k));
        @(negedge clock);
        bus.write = 1'b0;

        // Pairwise readback table
        for (int i = 0; i < 16; i++) begin
            bus.rs1 = vecs[i].rs1;
            bus.rs2 = vecs[i].rs2;
            #1;
            check($sformatf("fill_rd1[%0d]", vecs[i].rs1), bus.rdata1, vecs[i].exp1);
            check($sformatf("fill_rd2[%0d]", vecs[i].rs2), bus.rdata2, vecs[i].exp2);
        end

        // Write disabled leaves reg 5 alone
        @(negedge clock);
        bus.write  = 1'b0;
        bus.dr     = 5'd5;
        bus.wrdata = 32'hDEADBEEF;
        bus.rs1    = 5'd5;
        @(posedge clock);
        #1;
        check("wr_disable", bus.rdata1, 32'd50);

        // Old value before the edge, new value after it
        @(negedge clock);
        bus.rs1    = 5'd7;
        bus.write  = 1'b1;
        bus.dr     = 5'd7;
        bus.wrdata = 32'h1234;
        #1;
        check("timing_before", bus.rdata1, 32'd70);
        @(posedge clock);
        mdl_write(5'd7, 32'h1234);
        #1;
        check("timing_after", bus.rdata1, 32'h1234);
        @(negedge clock);
        bus.write = 1'b0;
        bus.rs2   = 5'd7;
        #1;
        check("same_addr_rd1", bus.rdata1, 32'h1234);
        check("same_addr_rd2", bus.rdata2, 32'h1234);

        // Register 0 behaviour depends on configuration
        write_cycle(5'd0, 32'hFFFFFFFF);
        @(negedge clock);
        bus.write = 1'b0;
        bus.rs1   = 5'd0;
        bus.rs2   = 5'd0;
        #1;
        check("reg0_rd1", bus.rdata1, ZERO_REG ? 32'd0 : 32'hFFFFFFFF);
        check("reg0_rd2", bus.rdata2, ZERO_REG ? 32'd0 : 32'hFFFFFFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            bus.write  = 1'($urandom);
            bus.dr     = 5'($urandom);
            bus.wrdata = $urandom;
            bus.rs1    = (n % 7 == 0) ? bus.dr : 5'($urandom);
            bus.rs2    = (n % 11 == 0) ? bus.rs1 : 5'($urandom);
            #1;
            check($sformatf("rand_rd1[%0d]", n), bus.rdata1, mdl_read(bus.rs1));
            check($sformatf("rand_rd2[%0d]", n), bus.rdata2, mdl_read(bus.rs2));
            @(posedge clock);
            if (bus.write) mdl_write(bus.dr, bus.wrdata);
        end

        // Distinct contents everywhere, then assert reset between edges
        for (int k = 0; k < 32; k++) write_cycle(5'(k), 32'hA5000000 | 32'(k + 1));
        @(negedge clock);
        bus.write = 1'b0;
        bus.rs1   = 5'd9;
        #1;
        check("pre_reset_rd1", bus.rdata1, mdl_read(5'd9));
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.rs1 = 5'(k);
            bus.rs2 = 5'(k + 16);
            #0.2;
            check($sformatf("async_rst_rd1[%0d]", k), bus.rdata1, 32'd0);
            check($sformatf("async_rst_rd2[%0d]", k + 16), bus.rdata2, 32'd0);
        end
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

        // Reset dominates a write on the same edge
        @(negedge clock);
        bus.write  = 1'b1;
        bus.dr     = 5'd3;
        bus.wrdata = 32'hCAFEF00D;
        bus.rs1    = 5'd3;
        @(posedge clock);
        #1;
        check("rst_over_write", bus.rdata1, 32'd0);
        @(negedge clock);
        bus.write = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("retain_after_rst", bus.rdata1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
